// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: N-digit multiplexed common-anode seven-segment driver with a
// sequential double-dabble converter, leading-zero blanking and blink modes.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_W       = 11,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter int LZB_EN      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BIN_W-1:0]        value,
  input  logic                    value_valid,
  output logic                    busy,
  output logic                    overflow,
  input  logic [1:0]              mode,
  input  logic [7*NUM_DIGITS-1:0] msg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int RC_W   = $clog2(REFRESH_DIV);
  localparam int BC_W   = $clog2(BLINK_DIV);
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  function automatic logic exceeds(input logic [BIN_W-1:0] v);
    logic [63:0] w;
    w = 64'd0;
    w[BIN_W-1:0] = v;
    return (w > MAX_VAL);
  endfunction

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      r[4*i+:4] = (b[4*i+:4] >= 4'd5) ? (b[4*i+:4] + 4'd3) : b[4*i+:4];
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] nines();
    logic [BCD_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) r[4*i+:4] = 4'd9;
    return r;
  endfunction

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'h7F;
    endcase
  endfunction

  typedef enum logic {S_IDLE, S_CONV} conv_state_t;

  conv_state_t            state_r, state_s;
  logic [BIN_W-1:0]       bin_sh_r;
  logic [BCD_W-1:0]       bcd_sh_r, bcd_r;
  logic [CNT_W-1:0]       iter_r;
  logic                   ovf_pend_r, busy_r, ovf_r;
  logic [RC_W-1:0]        ref_cnt_r;
  logic [SLOT_W-1:0]      slot_r;
  logic [BC_W-1:0]        blk_cnt_r;
  logic [1:0]             phase_r, mode_q_r;
  logic [NUM_DIGITS-1:0]  an_r, an_s;
  logic [6:0]             seg_r, seg_s, num_seg_s, msg_s;
  logic [3:0]             digit_s;
  logic                   lead_s, blank_lz_s;
  logic [BCD_W+BIN_W-1:0] shift_s;

  assign shift_s  = {add3(bcd_sh_r), bin_sh_r} << 1;
  assign busy     = busy_r;
  assign overflow = ovf_r;
  assign an       = an_r;
  assign seg      = seg_r;

  // Converter next-state: idle until a load, then BIN_W iterations
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  state_s = value_valid ? S_CONV : S_IDLE;
      S_CONV:  state_s = (iter_r == CNT_W'(1)) ? S_IDLE : S_CONV;
      default: state_s = S_IDLE;
    endcase
  end

  // Converter state and datapath: load, add-3/shift, commit with saturation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      ovf_r      <= 1'b0;
      ovf_pend_r <= 1'b0;
      bin_sh_r   <= '0;
      bcd_sh_r   <= '0;
      bcd_r      <= '0;
      iter_r     <= '0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == S_CONV);
      case (state_r)
        S_IDLE: begin
          if (value_valid) begin
            bin_sh_r   <= value;
            bcd_sh_r   <= '0;
            iter_r     <= CNT_W'(BIN_W);
            ovf_pend_r <= exceeds(value);
          end
        end
        S_CONV: begin
          bcd_sh_r <= shift_s[BCD_W+BIN_W-1:BIN_W];
          bin_sh_r <= shift_s[BIN_W-1:0];
          iter_r   <= iter_r - CNT_W'(1);
          if (iter_r == CNT_W'(1)) begin
            bcd_r <= ovf_pend_r ? nines() : shift_s[BCD_W+BIN_W-1:BIN_W];
            ovf_r <= ovf_pend_r;
          end
        end
        default: ;
      endcase
    end
  end

  // Refresh prescaler, slot index, blink prescaler and phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt_r <= '0;
      slot_r    <= '0;
      blk_cnt_r <= '0;
      phase_r   <= 2'd0;
      mode_q_r  <= 2'd0;
    end else begin
      if (ref_cnt_r == RC_W'(REFRESH_DIV - 1)) begin
        ref_cnt_r <= '0;
        slot_r    <= (slot_r == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot_r + SLOT_W'(1);
      end else begin
        ref_cnt_r <= ref_cnt_r + RC_W'(1);
      end
      mode_q_r <= mode;
      // A mode change restarts the blink sequence at phase 0
      if (mode != mode_q_r) begin
        blk_cnt_r <= '0;
        phase_r   <= 2'd0;
      end else if (blk_cnt_r == BC_W'(BLINK_DIV - 1)) begin
        blk_cnt_r <= '0;
        phase_r   <= phase_r + 2'd1;
      end else begin
        blk_cnt_r <= blk_cnt_r + BC_W'(1);
      end
    end
  end

  // Select current slot's digit, message pattern, anode and blanking
  always_comb begin
    digit_s    = 4'd0;
    msg_s      = 7'h7F;
    lead_s     = 1'b1;
    blank_lz_s = 1'b0;
    an_s       = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lead_s = lead_s & (bcd_r[4*(NUM_DIGITS-1-k)+:4] == 4'd0);
      an_s[NUM_DIGITS-1-k] = (SLOT_W'(k) != slot_r);
      digit_s    = (SLOT_W'(k) == slot_r) ? bcd_r[4*(NUM_DIGITS-1-k)+:4] : digit_s;
      msg_s      = (SLOT_W'(k) == slot_r) ? msg[7*k+:7] : msg_s;
      blank_lz_s = (SLOT_W'(k) == slot_r) ?
                   (lead_s && (k != NUM_DIGITS - 1) && (LZB_EN != 0)) : blank_lz_s;
    end
    num_seg_s = blank_lz_s ? 7'h7F : dec7(digit_s);
    case (mode_q_r)
      2'd0:    seg_s = num_seg_s;
      2'd1:    seg_s = phase_r[0] ? 7'h7F : num_seg_s;
      2'd2: begin
        case (phase_r)
          2'd0:    seg_s = msg_s;
          2'd2:    seg_s = num_seg_s;
          default: seg_s = 7'h7F;
        endcase
      end
      2'd3:    seg_s = msg_s;
      default: seg_s = 7'h7F;
    endcase
  end

  // Registered anode and segment outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_r  <= '1;
      seg_r <= 7'h7F;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_s;
    end
  end

endmodule
